// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: round-robin sharing of a 4-LED bank among 4 requesters,
// with a tick-based hold limit, a one-cycle gap between owners and a heartbeat.
module led_bank_arbiter #(
    parameter int TICK_DIV = 6000000,
    parameter int MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] req_data,
    output logic [3:0]  grant,
    output logic [3:0]  led_out,
    output logic        heartbeat,
    output logic        busy
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int HW = $clog2(MAX_HOLD + 1);
    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [HW-1:0] hold_q;
    logic [1:0]    ptr_q, owner_q, win;
    logic [3:0]    grant_q, led_q;
    logic          hb_q, busy_q, tick, others, hold_max;
    assign tick     = cnt_q == CW'(TICK_DIV - 1);
    assign others   = |(req & ~(4'b0001 << owner_q));
    assign hold_max = hold_q == HW'(MAX_HOLD);
    assign grant     = grant_q;
    assign led_out   = led_q;
    assign heartbeat = hb_q;
    assign busy      = busy_q;
    // Descending scan so the nearest index after ptr is the last (winning) assignment.
    always_comb begin
        win = ptr_q;
        for (int k = 4; k >= 1; k--)
            if (req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            hb_q  <= 1'b0;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            hb_q  <= hb_q ^ tick;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
            ptr_q   <= 2'd3;
            owner_q <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= OWN;
                        grant_q <= 4'b0001 << win;
                        owner_q <= win;
                        ptr_q   <= win;
                        led_q   <= req_data[4*win +: 4];
                        busy_q  <= 1'b1;
                        hold_q  <= '0;
                    end else begin
                        grant_q <= '0;
                        led_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                OWN: begin
                    if (!req[owner_q] || (hold_max && others)) begin
                        state_q <= GAP;
                        grant_q <= '0;
                        led_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        led_q <= req_data[4*owner_q +: 4];
                        if (tick && !hold_max) hold_q <= hold_q + 1'b1;
                    end
                end
                GAP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb_led_bank_arbiter: directed scenarios plus random traffic, checked against
// a cycle-level behavioural model of the arbitration rules.
module tb_led_bank_arbiter;
    localparam int TD = 10;
    localparam int MH = 2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] req_data = '0;
    logic [3:0]  grant, led_out;
    logic        heartbeat, busy;
    int checks = 0;
    int errors = 0;
    int m_mode, m_owner, m_ptr, m_hold, m_n;
    logic [3:0] m_led;
    always #5 clk = ~clk;
    led_bank_arbiter #(.TICK_DIV(TD), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .grant(grant), .led_out(led_out), .heartbeat(heartbeat), .busy(busy)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask
    // Mode: 0 idle, 1 owning, 2 gap. m_n counts edges since reset, so ticks and
    // heartbeat follow from plain division.
    task automatic model_step();
        int w;
        logic tk;
        if (rst) begin
            m_mode = 0; m_ptr = 3; m_owner = 0; m_hold = 0; m_n = 0; m_led = '0;
        end else begin
            tk = (m_n % TD) == TD - 1;
            if (m_mode == 0) begin
                if (req != 0) begin
                    w = -1;
                    for (int k = 1; k <= 4; k++)
                        if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                    m_mode = 1; m_ptr = w; m_owner = w; m_hold = 0;
                end
            end else if (m_mode == 1) begin
                if (!req[m_owner] || (m_hold == MH && (req & ~(4'b0001 << m_owner)) != 0))
                    m_mode = 2;
                else if (tk)
                    m_hold = (m_hold + 1 > MH) ? MH : m_hold + 1;
            end else begin
                m_mode = 0;
            end
            m_n++;
            m_led = (m_mode == 1) ? req_data[4*m_owner +: 4] : 4'b0;
        end
    endtask
    task automatic cyc(input logic r, input logic [3:0] q, input logic [15:0] d);
        @(negedge clk);
        rst = r; req = q; req_data = d;
        @(posedge clk);
        model_step();
        #1;
        chk("grant", 32'(grant), (m_mode == 1) ? 32'(4'b0001 << m_owner) : 32'd0);
        chk("led_out", 32'(led_out), 32'(m_led));
        chk("busy", 32'(busy), 32'(m_mode == 1));
        chk("heartbeat", 32'(heartbeat), 32'((m_n / TD) % 2));
        chk("onehot", 32'($countones(grant) <= 1), 32'd1);
    endtask
    initial begin
        logic [3:0] rq;
        int guard;
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b1111, 16'h4321);
        for (int i = 0; i < 25; i++) cyc(1'b0, 4'b0000, 16'h0000);
        cyc(1'b0, 4'b0001, 16'h000A);
        cyc(1'b0, 4'b0001, 16'h000A);
        cyc(1'b0, 4'b0001, 16'h0005);
        cyc(1'b0, 4'b0001, 16'h0005);
        cyc(1'b0, 4'b0000, 16'h0005);
        for (int i = 0; i < 200; i++) cyc(1'b0, 4'b1111, 16'hDB97);
        cyc(1'b1, 4'b0000, 16'h0000);
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0100, 16'h0C00);
        for (int i = 0; i < 2; i++) cyc(1'b0, 4'b0101, 16'h0C03);
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'b0001, 16'h0C03);
        cyc(1'b1, 4'b0000, 16'h0000);
        for (int i = 0; i < 110; i++) cyc(1'b0, 4'b0100, 16'h0600);
        guard = 0;
        while (!(m_mode == 1 && m_owner == 3) && guard < 200) begin
            cyc(1'b0, 4'b1111, 16'h8421);
            guard++;
        end
        chk("reach_owner3", 32'(guard < 200), 32'd1);
        cyc(1'b1, 4'b1111, 16'h8421);
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1111, 16'h8421);
        rq = 4'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) rq = 4'($urandom);
            cyc($urandom_range(299) == 0, rq, 16'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
